ultrasonic_ranger_mc: RTL and testbench

//  Multi-channel HC-SR04 style ranging controller; parametrised successor of the single-sensor trigger/echo counter.

---
 rtl/ultrasonic_ranger_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_ultrasonic_ranger_mc.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin HC-SR04 style ranging controller for N_CH sensors.
// Each slot fires one trigger pulse, times the synchronised echo in whole centimetres and stores the result.
module ultrasonic_ranger_mc #(
    parameter int N_CH        = 2,
    parameter int DIST_W      = 16,
    parameter int TRIG_CYC    = 500,
    parameter int CYC_PER_CM  = 2900,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int PERIOD_CYC  = 3000000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   dist_cm,
    output logic                     dist_valid,
    output logic [CH_W-1:0]          dist_ch,
    output logic [N_CH-1:0]          timeout,
    output logic                     busy,
    output logic [2:0]               dbg_state
);

    localparam int CNT_MAXV = (TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC;
    localparam int CNT_W    = $clog2(CNT_MAXV + 1);
    localparam int SLOT_W   = $clog2(PERIOD_CYC + TRIG_CYC + 2 * TIMEOUT_CYC + 4);
    localparam int SUB_W    = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = {SLOT_W{1'b1}};
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX    = {DIST_W{1'b1}};
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    // Handshake: dist_valid is a one-cycle strobe with no ready; dist_ch and the
    // written dist_cm/timeout entry are stable from that cycle until the next write.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [N_CH-1:0]     r_sync1;
    logic [N_CH-1:0]     r_sync2;
    logic [N_CH-1:0]     r_sync3;

    logic [CH_W-1:0]     r_ch;
    logic [CNT_W-1:0]    r_cnt;
    logic [SLOT_W-1:0]   r_slot;
    logic [SUB_W-1:0]    r_sub;
    logic [DIST_W-1:0]   r_cm;

    logic [DIST_W-1:0]   r_dist [N_CH];
    logic [N_CH-1:0]     r_tmo;
    logic                r_valid;
    logic [CH_W-1:0]     r_dist_ch;

    logic                w_echo_lvl;
    logic                w_rise;
    logic                w_fall;
    logic                w_start;
    logic                w_wr_norm;
    logic                w_wr_tmo;
    logic                w_adv;
    logic                w_tick;
    logic [SUB_W-1:0]    w_sub_base;
    logic [DIST_W-1:0]   w_cm_base;
    logic [SUB_W-1:0]    w_sub_inc;
    logic [DIST_W-1:0]   w_cm_inc;

    assign w_echo_lvl = r_sync2[r_ch];
    assign w_rise     = r_sync2[r_ch] & ~r_sync3[r_ch];
    assign w_fall     = ~r_sync2[r_ch] & r_sync3[r_ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= echo;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort on enable=0 takes priority in the active states; HOLDOFF always runs the slot out.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr_norm   = 1'b0;
        w_wr_tmo    = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_TRIG;
            end
            S_TRIG: begin
                if (!enable)                 w_state_nxt = S_IDLE;
                else if (r_cnt == TRIG_LAST) w_state_nxt = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                    w_start     = 1'b1;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_HOLDOFF;
                    w_wr_tmo    = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = S_HOLDOFF;
                    w_wr_norm   = 1'b1;
                end else if (r_cnt >= TMO_LAST) begin
                    w_state_nxt = S_HOLDOFF;
                    w_wr_tmo    = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (r_slot >= SLOT_LAST) begin
                    w_adv       = 1'b1;
                    w_state_nxt = enable ? S_TRIG : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The rise-detect cycle already has echo high, so it seeds the count with one tick.
    always_comb begin
        w_sub_base = w_start ? '0 : r_sub;
        w_cm_base  = w_start ? '0 : r_cm;
        w_sub_inc  = w_sub_base + SUB_W'(1);
        w_cm_inc   = w_cm_base;
        if (w_sub_base == SUB_LAST) begin
            w_sub_inc = '0;
            w_cm_inc  = (w_cm_base == CM_MAX) ? CM_MAX : w_cm_base + DIST_W'(1);
        end
        w_tick = w_start || ((r_state == S_MEASURE) && w_echo_lvl);
    end

    // r_cnt is a per-state timer; in MEASURE it holds the echo-high cycles seen so far.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_slot <= '0;
            r_sub  <= '0;
            r_cm   <= '0;
            r_ch   <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= w_start ? CNT_W'(1) : '0;
            end else if ((r_state == S_TRIG) || (r_state == S_WAIT_RISE) ||
                         (r_state == S_MEASURE)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((w_state_nxt == S_TRIG) && (r_state != S_TRIG)) begin
                r_slot <= '0;
            end else if ((r_state != S_IDLE) && (r_slot != SLOT_MAX)) begin
                r_slot <= r_slot + SLOT_W'(1);
            end

            if (w_tick) begin
                r_sub <= w_sub_inc;
                r_cm  <= w_cm_inc;
            end

            if (w_adv) begin
                r_ch <= (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_dist[k] <= '0;
            end
            r_tmo     <= '0;
            r_valid   <= 1'b0;
            r_dist_ch <= '0;
        end else begin
            r_valid <= w_wr_norm | w_wr_tmo;
            if (w_wr_norm || w_wr_tmo) begin
                r_dist[r_ch] <= w_wr_tmo ? CM_MAX : r_cm;
                r_tmo[r_ch]  <= w_wr_tmo;
                r_dist_ch    <= r_ch;
            end
        end
    end

    // Trigger follows enable combinationally so an abort drops the pin in the same cycle.
    always_comb begin
        trigger = '0;
        if ((r_state == S_TRIG) && enable) begin
            trigger[r_ch] = 1'b1;
        end
    end

    always_comb begin
        dist_cm = '0;
        for (int k = 0; k < N_CH; k++) begin
            dist_cm[k*DIST_W +: DIST_W] = r_dist[k];
        end
    end

    assign dist_valid = r_valid;
    assign dist_ch    = r_dist_ch;
    assign timeout    = r_tmo;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Randomised bench for ultrasonic_ranger_mc: drives echo pulses per slot and checks results
// against a per-slot model of distance = floor(high_cycles / CYC_PER_CM), saturated.
module tb_ultrasonic_ranger_mc;

    localparam int N_CH        = 2;
    localparam int DIST_W      = 4;
    localparam int TRIG_CYC    = 5;
    localparam int CYC_PER_CM  = 10;
    localparam int TIMEOUT_CYC = 400;
    localparam int PERIOD_CYC  = 1000;
    localparam int CH_W        = 1;
    localparam int DMAX        = (1 << DIST_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trigger;
    logic [N_CH*DIST_W-1:0] dist_cm;
    logic                   dist_valid;
    logic [CH_W-1:0]        dist_ch;
    logic [N_CH-1:0]        timeout;
    logic                   busy;
    logic [2:0]             dbg_state;

    ultrasonic_ranger_mc #(
        .N_CH(N_CH), .DIST_W(DIST_W), .TRIG_CYC(TRIG_CYC), .CYC_PER_CM(CYC_PER_CM),
        .TIMEOUT_CYC(TIMEOUT_CYC), .PERIOD_CYC(PERIOD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trigger(trigger),
        .dist_cm(dist_cm), .dist_valid(dist_valid), .dist_ch(dist_ch),
        .timeout(timeout), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_dist [N_CH];
    int exp_tmo  [N_CH];
    int next_ch   = 0;
    int last_rise = 0;
    bit have_rise = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int get_dist(input int k);
        return int'(dist_cm[k*DIST_W +: DIST_W]);
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("%s_dist%0d", tag, k), get_dist(k), exp_dist[k]);
            check($sformatf("%s_tmo%0d", tag, k), int'(timeout[k]), exp_tmo[k]);
        end
    endtask

    task automatic noise(input int ch);
        for (int k = 0; k < N_CH; k++) begin
            if (k != ch && $urandom_range(0, 3) == 0) echo[k] = ~echo[k];
        end
    endtask

    task automatic quiet_others(input int ch);
        for (int k = 0; k < N_CH; k++) begin
            if (k != ch) echo[k] = 1'b0;
        end
    endtask

    task automatic wait_trig_rise();
        int n = 0;
        while (trigger == '0 && n < PERIOD_CYC + 50) begin
            step();
            n++;
        end
        if (trigger == '0) check("trig_rise_seen", 0, 1);
    endtask

    // Waits through the trigger pulse of the current slot; returns with WAIT_RISE active.
    task automatic trig_phase(input int ch, input bit chk_period);
        int w = 0;
        wait_trig_rise();
        check("trig_onehot", int'(trigger), 1 << ch);
        check("busy_in_slot", int'(busy), 1);
        if (chk_period && have_rise) check("slot_period", cyc - last_rise, PERIOD_CYC);
        last_rise = cyc;
        have_rise = 1'b1;
        while (trigger != '0 && w < 50) begin
            step();
            w++;
        end
        check("trig_width", w, TRIG_CYC);
    endtask

    // mode 0: echo of h cycles, mode 1: no echo, mode 2: echo stuck high
    task automatic run_slot(input int mode, input int h, input bit chk_period);
        int ch = next_ch;
        int n  = 0;
        int d;
        int e;
        bit seen = 1'b0;
        trig_phase(ch, chk_period);
        if (mode == 1) begin
            while (!dist_valid && n < 2 * TIMEOUT_CYC) begin
                noise(ch);
                step();
                n++;
            end
            check("norise_tmo_latency", n, TIMEOUT_CYC);
            exp_dist[ch] = DMAX;
            exp_tmo[ch]  = 1;
        end else begin
            d = $urandom_range(1, 40);
            repeat (d) begin
                noise(ch);
                step();
            end
            echo[ch] = 1'b1;
            if (mode == 0) begin
                repeat (h) begin
                    noise(ch);
                    step();
                    if (dist_valid) seen = 1'b1;
                end
                echo[ch] = 1'b0;
                while (!dist_valid && n < 20) begin
                    step();
                    n++;
                end
                check("no_early_valid", int'(seen), 0);
                check("fall_to_valid", n, 3);
                e = h / CYC_PER_CM;
                if (e > DMAX) e = DMAX;
                exp_dist[ch] = e;
                exp_tmo[ch]  = 0;
            end else begin
                while (!dist_valid && n < 3 * TIMEOUT_CYC) begin
                    noise(ch);
                    step();
                    n++;
                end
                check("stuck_tmo_window", int'(n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 4), 1);
                echo[ch] = 1'b0;
                exp_dist[ch] = DMAX;
                exp_tmo[ch]  = 1;
            end
        end
        check("valid_seen", int'(dist_valid), 1);
        check("valid_ch", int'(dist_ch), ch);
        check_all($sformatf("slot_m%0d_h%0d", mode, h));
        step();
        check("valid_one_cycle", int'(dist_valid), 0);
        quiet_others(ch);
        next_ch = (ch + 1) % N_CH;
    endtask

    task automatic enter_measure(input int ch);
        trig_phase(ch, 1'b0);
        repeat ($urandom_range(1, 30)) step();
        echo[ch] = 1'b1;
        repeat (20) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trigger"}, int'(trigger), 0);
        check({tag, "_dist_cm"}, int'(dist_cm), 0);
        check({tag, "_valid"}, int'(dist_valid), 0);
        check({tag, "_dist_ch"}, int'(dist_ch), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            exp_dist[k] = 0;
            exp_tmo[k]  = 0;
        end
        next_ch   = 0;
        have_rise = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int n;
        int r;
        reset  = 1'b1;
        enable = 1'b0;
        echo   = '0;
        model_reset();
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) step();
        check("idle_when_disabled", int'(busy), 0);

        enable = 1'b1;
        run_slot(0, 125, 1'b1);
        run_slot(1, 0, 1'b1);
        run_slot(0, 9, 1'b1);
        run_slot(0, 300, 1'b1);
        run_slot(2, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 9);
            run_slot((r < 6) ? 0 : ((r < 8) ? 1 : 2), $urandom_range(1, 380), 1'b1);
        end

        // abort in MEASURE: no write, same channel restarts
        enter_measure(next_ch);
        enable = 1'b0;
        #1;
        check("abort_meas_trig_low", int'(trigger), 0);
        step();
        check("abort_meas_idle", int'(busy), 0);
        seen = 0;
        repeat (30) begin
            step();
            if (dist_valid) seen = 1;
        end
        check("abort_meas_no_valid", seen, 0);
        echo = '0;
        check_all("abort_meas_kept");
        repeat (5) step();
        enable = 1'b1;
        have_rise = 1'b0;
        run_slot(0, $urandom_range(1, 380), 1'b0);

        // abort in TRIG: trigger drops in the same cycle
        wait_trig_rise();
        step();
        step();
        enable = 1'b0;
        #1;
        check("abort_trig_drop", int'(trigger), 0);
        step();
        check("abort_trig_idle", int'(busy), 0);
        repeat (5) step();
        enable = 1'b1;
        have_rise = 1'b0;
        run_slot(0, $urandom_range(1, 380), 1'b0);

        // disable during HOLDOFF: slot runs to its end, then IDLE, pointer advanced
        enable = 1'b0;
        n = 0;
        seen = 0;
        while (busy && n < PERIOD_CYC + 50) begin
            step();
            n++;
            if (trigger != '0) seen = 1;
        end
        check("holdoff_reaches_idle", int'(busy), 0);
        check("holdoff_slot_end", cyc - last_rise, PERIOD_CYC);
        check("holdoff_no_trigger", seen, 0);
        repeat (10) step();
        enable = 1'b1;
        have_rise = 1'b0;
        run_slot(0, $urandom_range(1, 380), 1'b0);

        // reset mid-TRIG
        wait_trig_rise();
        step();
        step();
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_trig");
        model_reset();
        step();
        reset = 1'b0;
        run_slot(0, $urandom_range(1, 380), 1'b0);

        // reset mid-MEASURE
        enter_measure(next_ch);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_meas");
        model_reset();
        echo = '0;
        step();
        reset = 1'b0;
        run_slot(0, $urandom_range(1, 380), 1'b0);
        run_slot(1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
